if_id_skid_reg: RTL
===================

// Module: if_id_skid_reg
// PURPOSE
//  Parametrised IF->ID pipeline register with a valid/ready handshake and a 2-entry skid buffer.
//  It decouples instruction fetch from decode, so a decode stall never drops the fetch in flight.
//  It accepts a flush (jump/branch redirect) and a global pause (rdy_in).
//  It replaces the fixed-width IF/ID latch between the IF stage and the ID stage.
// PARAMETERS
//  ADDR_W   32  width of the pc field
//  INST_W   32  width of the instruction field
//  NOP_INST 0   value driven on inst_out when out_valid=0 (width INST_W)
// PORTS
//  clk_in      in   1       clock; all state updates on the rising edge
//  rst_n_in    in   1       asynchronous reset, active-low
//  rdy_in      in   1       global ready; 0 freezes all state
//  flush_in    in   1       redirect (jump/branch taken); discards all held entries
//  in_valid    in   1       IF presents pc_in/inst_in
//  in_ready    out  1       block can accept an entry this cycle
//  pc_in       in   ADDR_W  fetched pc
//  inst_in     in   INST_W  fetched instruction
//  out_valid   out  1       ID-side entry valid
//  out_ready   in   1       ID consumes the entry this cycle
//  pc_out      out  ADDR_W  pc to ID (0 when out_valid=0)
//  inst_out    out  INST_W  instruction to ID (NOP_INST when out_valid=0)
//  occupancy   out  2       held entries, 0..2
// BEHAVIOUR
//  - Reset (rst_n_in=0, asynchronous): state=EMPTY; out_valid=0; pc_out=0; inst_out=NOP_INST; occupancy=0; skid entry cleared.
//  - Handshakes: acc = in_valid & in_ready; pop = out_valid & out_ready; both are qualified by rdy_in=1 and flush_in=0.
//  - States: EMPTY (0 entries), ONE (main entry valid), FULL (main + skid valid).
//  - in_ready = rdy_in & (state!=FULL). It is derived from registered state only; there is no comb path from out_ready.
//  - out_valid = rdy_in & (state!=EMPTY).
//  - Transitions:
//    - EMPTY: acc -> ONE; the input loads the main entry.
//    - ONE: acc & pop -> ONE, main <= input. acc & !pop -> FULL, skid <= input. pop & !acc -> EMPTY.
//    - FULL: pop -> ONE; main <= skid, skid cleared. No acc is possible in FULL.
//  - Latency: an entry accepted into EMPTY is visible on the outputs on the next cycle, i.e. 1 cycle.
//  - Ordering is strictly FIFO: the skid entry is always older than any new input.
//  - flush_in=1 (rdy_in=1): the next state is EMPTY and both entries are zeroed.
//    - A concurrent in_valid is dropped.
//    - A concurrent out_ready is ignored (pop=0).
//    - Flush has priority over every other event.
//  - rdy_in=0: no state change, including on flush. Outputs read as invalid (out_valid=0, in_ready=0); stored data is retained.
//  - Data outputs are registered and forced to 0/NOP_INST whenever the main entry is invalid. This keeps the old zero-bubble property.
//  - occupancy equals the state encoding (EMPTY=0, ONE=1, FULL=2) and is ungated by rdy_in.
//  - Reset asserted mid-operation drops all entries immediately, without waiting for a clock edge.
// STRUCTURE
//  - pipe_pkg (shared): state enum {EMPTY, ONE, FULL} with a 2-bit encoding.
//  - pipe_pkg (shared): constant NOP_INST_DEFAULT = 32'h0.
//  - pipe_pkg (shared): handshake helper macros, reused by the later ID/EX and EX/MEM skid registers.
//  - Sub-module pipe_slot: one {valid, pc, inst} register with load/clear/async reset, instantiated twice (main, skid).
//  - Top level: state machine, muxing and output gating.
// TESTING
//  1. Reset: hold rst_n_in=0 mid-clock.
//     Required: out_valid=0, pc_out=0, inst_out=0 and occupancy=0 immediately, before any clock edge.
//  2. Streaming: in_valid=1 with pc 0x0,0x4,0x8 on consecutive cycles, out_ready=1.
//     Required: out_valid from cycle 1; pc_out 0x0,0x4,0x8 on cycles 1,2,3; occupancy stays 1; in_ready stays 1.
//  3. Backpressure: hold out_ready=0 while pushing pc 0x10, then 0x14.
//     Required: occupancy 1 then 2; in_ready=0 in FULL; pc_out holds 0x10.
//     Then release out_ready. Required: pops are 0x10 then 0x14 in order, with no loss.
//  4. Flush while FULL with in_valid=1 (pc 0x20) and out_ready=1.
//     Required next cycle: occupancy=0, out_valid=0, inst_out=NOP_INST; 0x20 is never emitted.
//  5. Pause: set rdy_in=0 for 3 cycles while in ONE, toggling in_valid/out_ready/flush_in.
//     Required: state, pc_out and inst_out unchanged; out_valid=0 and in_ready=0 during the pause; the held entry reappears afterwards.
//  6. Parameters: ADDR_W=16, INST_W=16, NOP_INST=16'h0013, push inst 0xABCD.
//     Required: inst_out=0xABCD when valid and 0x0013 when empty.

Source files
------------

// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared state encoding, NOP constant and handshake macros for pipeline skid registers
`ifndef PIPE_PKG_SV
`define PIPE_PKG_SV

`define PIPE_XFER(valid, ready, rdy, flush) ((valid) & (ready) & (rdy) & ~(flush))
`define PIPE_ACC(valid, ready, rdy, flush) `PIPE_XFER(valid, ready, rdy, flush)
`define PIPE_POP(valid, ready, rdy, flush) `PIPE_XFER(valid, ready, rdy, flush)

package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } pipe_state_e;

  localparam logic [31:0] NOP_INST_DEFAULT = 32'h0;

endpackage

`endif

// File: rtl/pipe_slot.sv
// rtl/pipe_slot.sv - one {valid, pc, inst} holding register with load, clear and async reset
module pipe_slot #(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic              load,
  input  logic              clear,
  input  logic [ADDR_W-1:0] pc_d,
  input  logic [INST_W-1:0] inst_d,
  output logic              valid,
  output logic [ADDR_W-1:0] pc,
  output logic [INST_W-1:0] inst
);

  // Clear wins over load so a redirect can never be overtaken by a fetch.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      valid <= 1'b0;
      pc    <= '0;
      inst  <= '0;
    end else if (clear) begin
      valid <= 1'b0;
      pc    <= '0;
      inst  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      pc    <= pc_d;
      inst  <= inst_d;
    end
  end

endmodule

// File: rtl/if_id_skid_reg.sv
// rtl/if_id_skid_reg.sv - IF->ID pipeline register with valid/ready handshake and 2-entry skid buffer
module if_id_skid_reg
  import pipe_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                INST_W   = 32,
  parameter logic [INST_W-1:0] NOP_INST = INST_W'(NOP_INST_DEFAULT)
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic              rdy_in,
  input  logic              flush_in,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic [INST_W-1:0] inst_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] pc_out,
  output logic [INST_W-1:0] inst_out,
  output logic [1:0]        occupancy
);

  pipe_state_e       state;
  logic              acc, pop, wipe;
  logic              main_load, main_clear, main_from_skid;
  logic              skid_load, skid_clear;
  logic              main_valid, skid_valid;
  logic [ADDR_W-1:0] main_pc, skid_pc, main_pc_d;
  logic [INST_W-1:0] main_inst, skid_inst, main_inst_d;

  // Ready is a function of registered state only, so ID stalls never reach IF combinationally.
  assign in_ready  = rdy_in & (state != FULL);
  assign out_valid = rdy_in & (state != EMPTY);
  assign acc       = `PIPE_ACC(in_valid, in_ready, rdy_in, flush_in);
  assign pop       = `PIPE_POP(out_valid, out_ready, rdy_in, flush_in);
  assign wipe      = rdy_in & flush_in;

  always_comb begin
    main_load      = 1'b0;
    main_clear     = wipe;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    skid_clear     = wipe;
    if (!wipe) begin
      case (state)
        EMPTY: main_load = acc;
        ONE: begin
          if (acc && !pop)      skid_load  = 1'b1;
          else if (acc)         main_load  = 1'b1;
          else if (pop)         main_clear = 1'b1;
        end
        FULL: begin
          if (pop) begin
            main_load      = 1'b1;
            main_from_skid = 1'b1;
            skid_clear     = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign main_pc_d   = main_from_skid ? skid_pc   : pc_in;
  assign main_inst_d = main_from_skid ? skid_inst : inst_in;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state <= EMPTY;
    end else if (wipe) begin
      state <= EMPTY;
    end else begin
      case (state)
        EMPTY:   if (acc) state <= ONE;
        ONE:     if (acc && !pop) state <= FULL;
                 else if (pop && !acc) state <= EMPTY;
        FULL:    if (pop) state <= ONE;
        default: state <= EMPTY;
      endcase
    end
  end

  pipe_slot #(.ADDR_W(ADDR_W), .INST_W(INST_W)) u_main (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .load     (main_load),
    .clear    (main_clear),
    .pc_d     (main_pc_d),
    .inst_d   (main_inst_d),
    .valid    (main_valid),
    .pc       (main_pc),
    .inst     (main_inst)
  );

  pipe_slot #(.ADDR_W(ADDR_W), .INST_W(INST_W)) u_skid (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .load     (skid_load),
    .clear    (skid_clear),
    .pc_d     (pc_in),
    .inst_d   (inst_in),
    .valid    (skid_valid),
    .pc       (skid_pc),
    .inst     (skid_inst)
  );

  // Gate on the main slot rather than rdy_in so a paused entry keeps showing its data.
  assign pc_out    = main_valid ? main_pc   : '0;
  assign inst_out  = main_valid ? main_inst : NOP_INST;
  assign occupancy = state;

  logic unused_ok;
  assign unused_ok = skid_valid;

endmodule
